ddr4_cmd_monitor: RTL and testbench



---
 rtl/ddr4_mon_pkg.sv | 54 +++++
 rtl/ddr4_mon_bank.sv | 45 ++++
 rtl/ddr4_cmd_monitor.sv | 159 +++++++++++++++
 tb/tb_ddr4_cmd_monitor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ddr4_mon_pkg.sv
// Shared types for the DDR4 command monitor: command and error codes,
// plus the truth-table decoder used on the sampled command pins.
package ddr4_mon_pkg;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_MRS  = 4'd2,
        CMD_REF  = 4'd3,
        CMD_PRE  = 4'd4,
        CMD_PREA = 4'd5,
        CMD_RD   = 4'd6,
        CMD_RDA  = 4'd7,
        CMD_WR   = 4'd8,
        CMD_WRA  = 4'd9,
        CMD_ZQC  = 4'd10,
        CMD_RFU  = 4'd11
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_MULTI_CS  = 3'd1,
        ERR_ACT_OPEN  = 3'd2,
        ERR_RW_CLOSED = 3'd3,
        ERR_REF_OPEN  = 3'd4,
        ERR_TRCD      = 3'd5,
        ERR_TRP       = 3'd6,
        ERR_RFU       = 3'd7
    } err_e;

    // pins = {act_n, A16 (RAS), A15 (CAS), A14 (WE), A10}
    function automatic cmd_e decode_cmd(input logic [4:0] pins);
        cmd_e c;
        if (!pins[4]) c = CMD_ACT;
        else begin
            case (pins[3:1])
                3'b000:  c = CMD_MRS;
                3'b001:  c = CMD_REF;
                3'b010:  c = pins[0] ? CMD_PREA : CMD_PRE;
                3'b011:  c = CMD_RFU;
                3'b100:  c = pins[0] ? CMD_WRA : CMD_WR;
                3'b101:  c = pins[0] ? CMD_RDA : CMD_RD;
                3'b110:  c = CMD_ZQC;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

    function automatic logic is_rw(input cmd_e c);
        return c inside {CMD_RD, CMD_RDA, CMD_WR, CMD_WRA};
    endfunction

endpackage

// File: rtl/ddr4_mon_bank.sv
// One DDR4 bank as seen from the command bus: open/closed bit, the row last
// activated, and a saturating cycles-since-ACT/PRE counter for tRCD/tRP.
module ddr4_mon_bank #(
    parameter int ROW_BITS = 17,
    parameter int TRCD     = 16,
    parameter int TRP      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                act,
    input  logic                close,
    input  logic [ROW_BITS-1:0] row_in,
    output logic                is_open,
    output logic [ROW_BITS-1:0] row,
    output logic                rcd_ok,
    output logic                rp_ok
);
    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int CW   = $clog2(TMAX + 1);

    // 'since' holds the distance k, in edges, that a command sampled at the
    // next edge would have from the last ACT/PRE; hence it restarts at 1.
    logic [CW-1:0] since;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_open <= 1'b0;
            row     <= '0;
            since   <= CW'(TMAX);
        end else begin
            if (act) begin
                is_open <= 1'b1;
                row     <= row_in;
            end else if (close) begin
                is_open <= 1'b0;
            end
            if (act || close)            since <= CW'(1);
            else if (since != CW'(TMAX)) since <= since + CW'(1);
        end
    end

    assign rcd_ok = since >= CW'(TRCD);
    assign rp_ok  = since >= CW'(TRP);

endmodule

// File: rtl/ddr4_cmd_monitor.sv
// Non-intrusive DDR4 command-bus monitor: decodes each sampled command,
// tracks per-bank state and timing, flags protocol errors, counts commands.
module ddr4_cmd_monitor
    import ddr4_mon_pkg::*;
#(
    parameter int RANKS    = 1,
    parameter int BG_BITS  = 2,
    parameter int BA_BITS  = 2,
    parameter int ROW_BITS = 17,
    parameter int TRCD     = 16,
    parameter int TRP      = 16,
    parameter int CNT_W    = 32,
    localparam int NB      = 2 ** (BG_BITS + BA_BITS),
    localparam int RB      = (RANKS > 1) ? $clog2(RANKS) : 1,
    localparam int BANK_W  = BG_BITS + BA_BITS + RB,
    localparam int NT      = RANKS * NB
) (
    input  logic                c0_ddr4_ck_t,
    input  logic                c0_ddr4_reset_n,
    input  logic                c0_ddr4_cke,
    input  logic [RANKS-1:0]    c0_ddr4_cs_n,
    input  logic                c0_ddr4_act_n,
    input  logic [16:0]         c0_ddr4_adr,
    input  logic [BG_BITS-1:0]  c0_ddr4_bg,
    input  logic [BA_BITS-1:0]  c0_ddr4_ba,
    input  logic                clr_cnt,
    output logic                cmd_valid,
    output logic [3:0]          cmd_code,
    output logic [BANK_W-1:0]   cmd_bank,
    output logic [ROW_BITS-1:0] cmd_row,
    output logic [9:0]          cmd_col,
    output logic [NT-1:0]       open_banks,
    output logic                err_valid,
    output logic [2:0]          err_code,
    output logic [CNT_W-1:0]    act_cnt,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    wr_cnt
);
    logic [2:0]        n_sel;
    logic [RB-1:0]     rank;
    logic              multi, do_cmd;
    cmd_e              cmd;
    logic [BANK_W-1:0] idx;

    always_comb begin
        n_sel = '0;
        rank  = '0;
        for (int r = 0; r < RANKS; r++) begin
            if (!c0_ddr4_cs_n[r]) begin
                n_sel = n_sel + 3'd1;
                rank  = RB'(r);
            end
        end
    end

    assign multi  = c0_ddr4_cke && (n_sel > 3'd1);
    assign cmd    = decode_cmd({c0_ddr4_act_n, c0_ddr4_adr[16:14], c0_ddr4_adr[10]});
    assign do_cmd = c0_ddr4_cke && (n_sel == 3'd1) && (cmd != CMD_NOP);
    assign idx    = {rank, c0_ddr4_bg, c0_ddr4_ba};

    logic [NT-1:0]       bank_open, rcd_ok, rp_ok, hit, in_rank, act_b, close_b;
    logic [ROW_BITS-1:0] rows [NT];

    for (genvar i = 0; i < NT; i++) begin : g_bank
        assign hit[i]     = (idx == BANK_W'(i));
        assign in_rank[i] = (rank == RB'(i / NB));
        assign act_b[i]   = do_cmd && (cmd == CMD_ACT) && hit[i];
        assign close_b[i] = do_cmd && ((hit[i] && (cmd inside {CMD_PRE, CMD_RDA, CMD_WRA}))
                                    || (in_rank[i] && (cmd == CMD_PREA)));

        ddr4_mon_bank #(.ROW_BITS(ROW_BITS), .TRCD(TRCD), .TRP(TRP)) u_bank (
            .clk    (c0_ddr4_ck_t),
            .rst_n  (c0_ddr4_reset_n),
            .act    (act_b[i]),
            .close  (close_b[i]),
            .row_in (c0_ddr4_adr[ROW_BITS-1:0]),
            .is_open(bank_open[i]),
            .row    (rows[i]),
            .rcd_ok (rcd_ok[i]),
            .rp_ok  (rp_ok[i])
        );
    end

    assign open_banks = bank_open;

    logic                sel_open, sel_rcd, sel_rp, rank_open;
    logic [ROW_BITS-1:0] sel_row, row_d;
    err_e                err_d;

    always_comb begin
        sel_open = 1'b0;
        sel_rcd  = 1'b0;
        sel_rp   = 1'b0;
        sel_row  = '0;
        for (int i = 0; i < NT; i++) begin
            if (hit[i]) begin
                sel_open = bank_open[i];
                sel_rcd  = rcd_ok[i];
                sel_rp   = rp_ok[i];
                sel_row  = rows[i];
            end
        end
    end

    assign rank_open = |(bank_open & in_rank);

    // Single error per cycle, most severe first; the command is still reported.
    always_comb begin
        err_d = ERR_NONE;
        if (multi) err_d = ERR_MULTI_CS;
        else if (do_cmd) begin
            if      (cmd == CMD_ACT && sel_open)   err_d = ERR_ACT_OPEN;
            else if (is_rw(cmd) && !sel_open)      err_d = ERR_RW_CLOSED;
            else if (cmd == CMD_REF && rank_open)  err_d = ERR_REF_OPEN;
            else if (is_rw(cmd) && !sel_rcd)       err_d = ERR_TRCD;
            else if (cmd == CMD_ACT && !sel_rp)    err_d = ERR_TRP;
            else if (cmd == CMD_RFU)               err_d = ERR_RFU;
        end
    end

    always_comb begin
        row_d = '0;
        if (do_cmd && cmd == CMD_ACT) row_d = c0_ddr4_adr[ROW_BITS-1:0];
        else if (do_cmd && is_rw(cmd)) row_d = sel_row;
    end

    always_ff @(posedge c0_ddr4_ck_t or negedge c0_ddr4_reset_n) begin
        if (!c0_ddr4_reset_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            act_cnt   <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            cmd_valid <= do_cmd;
            cmd_code  <= do_cmd ? cmd : CMD_NOP;
            cmd_bank  <= do_cmd ? idx : '0;
            cmd_row   <= row_d;
            cmd_col   <= (do_cmd && is_rw(cmd)) ? c0_ddr4_adr[9:0] : '0;
            err_valid <= (err_d != ERR_NONE);
            err_code  <= err_d;
            if (clr_cnt) begin
                act_cnt <= '0;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
            end else if (do_cmd) begin
                if (cmd == CMD_ACT && act_cnt != '1) act_cnt <= act_cnt + CNT_W'(1);
                if ((cmd inside {CMD_RD, CMD_RDA}) && rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
                if ((cmd inside {CMD_WR, CMD_WRA}) && wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_monitor.sv
// Directed bench for ddr4_cmd_monitor (2 ranks, 4-bit counters): a vector
// table for single-command cases plus hand sequences for saturation and reset.
module tb_ddr4_cmd_monitor;

    localparam logic [3:0] C_NOP = 4'd0, C_ACT = 4'd1, C_MRS = 4'd2, C_REF = 4'd3,
                           C_PRE = 4'd4, C_PREA = 4'd5, C_RD = 4'd6, C_RDA = 4'd7,
                           C_WR = 4'd8, C_ZQC = 4'd10, C_RFU = 4'd11;
    localparam logic [2:0] E_MCS = 3'd1, E_ACTO = 3'd2, E_RWC = 3'd3, E_REFO = 3'd4,
                           E_TRCD = 3'd5, E_TRP = 3'd6, E_RFU = 3'd7;
    localparam logic [2:0] O_MRS = 3'b000, O_REF = 3'b001, O_PRE = 3'b010, O_RFU = 3'b011,
                           O_WR = 3'b100, O_RD = 3'b101, O_ZQC = 3'b110, O_NOP = 3'b111;
    localparam logic [1:0] R0 = 2'b10, R1 = 2'b01, DS = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n, cke, act_n, clr;
    logic [1:0]  cs_n, bg, ba;
    logic [16:0] adr;
    logic        cmd_valid, err_valid;
    logic [3:0]  cmd_code, act_cnt, rd_cnt, wr_cnt;
    logic [4:0]  cmd_bank;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [31:0] open_banks;
    logic [2:0]  err_code;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr4_cmd_monitor #(.RANKS(2), .CNT_W(4)) dut (
        .c0_ddr4_ck_t(clk), .c0_ddr4_reset_n(rst_n), .c0_ddr4_cke(cke),
        .c0_ddr4_cs_n(cs_n), .c0_ddr4_act_n(act_n), .c0_ddr4_adr(adr),
        .c0_ddr4_bg(bg), .c0_ddr4_ba(ba), .clr_cnt(clr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .open_banks(open_banks),
        .err_valid(err_valid), .err_code(err_code),
        .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    typedef struct {
        int          gap;
        logic        cke;
        logic [1:0]  cs_n;
        logic        act_n;
        logic [16:0] adr;
        logic [1:0]  bg, ba;
        logic        clr;
        logic        cv;
        logic [3:0]  code;
        logic [4:0]  bank;
        logic [16:0] row;
        logic [9:0]  col;
        logic        ev;
        logic [2:0]  ec;
        logic [31:0] ob;
        logic [3:0]  ac, rc, wc;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [16:0] op(input logic [2:0] o, input logic a10, input logic [9:0] col);
        return {o, 3'b000, a10, col};
    endfunction

    function automatic vec_t v(input int gap, input logic k, input logic [1:0] cs, input logic an,
                               input logic [16:0] a, input logic [1:0] g, input logic [1:0] b,
                               input logic c, input logic cv, input logic [3:0] code,
                               input logic [4:0] bank, input logic [16:0] row, input logic [9:0] col,
                               input logic ev, input logic [2:0] ec, input logic [31:0] ob,
                               input logic [3:0] ac, input logic [3:0] rc, input logic [3:0] wc);
        vec_t t;
        t.gap = gap; t.cke = k; t.cs_n = cs; t.act_n = an; t.adr = a; t.bg = g; t.ba = b; t.clr = c;
        t.cv = cv; t.code = code; t.bank = bank; t.row = row; t.col = col;
        t.ev = ev; t.ec = ec; t.ob = ob; t.ac = ac; t.rc = rc; t.wc = wc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle();
        cke = 1'b1; cs_n = DS; act_n = 1'b1; adr = op(O_NOP, 1'b0, 10'd0);
        bg = 2'd0; ba = 2'd0; clr = 1'b0;
    endtask

    task automatic cyc(input logic [1:0] cs, input logic an, input logic [16:0] a,
                       input logic [1:0] g, input logic [1:0] b, input logic c);
        cke = 1'b1; cs_n = cs; act_n = an; adr = a; bg = g; ba = b; clr = c;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic apply(input int i, input vec_t t);
        for (int g = 0; g < t.gap; g++) begin
            @(posedge clk); #1;
        end
        cke = t.cke; cs_n = t.cs_n; act_n = t.act_n; adr = t.adr;
        bg = t.bg; ba = t.ba; clr = t.clr;
        @(posedge clk); #1;
        chk($sformatf("v%0d cmd_valid", i), 32'(cmd_valid), 32'(t.cv));
        chk($sformatf("v%0d cmd_code", i), 32'(cmd_code), 32'(t.code));
        chk($sformatf("v%0d cmd_bank", i), 32'(cmd_bank), 32'(t.bank));
        chk($sformatf("v%0d cmd_row", i), 32'(cmd_row), 32'(t.row));
        chk($sformatf("v%0d cmd_col", i), 32'(cmd_col), 32'(t.col));
        chk($sformatf("v%0d err_valid", i), 32'(err_valid), 32'(t.ev));
        chk($sformatf("v%0d err_code", i), 32'(err_code), 32'(t.ec));
        chk($sformatf("v%0d open_banks", i), open_banks, t.ob);
        chk($sformatf("v%0d act_cnt", i), 32'(act_cnt), 32'(t.ac));
        chk($sformatf("v%0d rd_cnt", i), 32'(rd_cnt), 32'(t.rc));
        chk($sformatf("v%0d wr_cnt", i), 32'(wr_cnt), 32'(t.wc));
        idle();
    endtask

    initial begin
        // Bank 6 = rank0 bg1 ba2; rank1 banks start at bit 16.
        vecs[0]  = v(0,  1, R0, 0, 17'h1234, 1, 2, 0, 1, C_ACT, 5'd6, 17'h1234, 10'h0, 0, 0, 32'h40, 1, 0, 0);
        vecs[1]  = v(15, 1, R0, 1, op(O_RD, 0, 10'h040), 1, 2, 0, 1, C_RD, 5'd6, 17'h1234, 10'h040, 0, 0, 32'h40, 1, 1, 0);
        vecs[2]  = v(0,  1, R0, 1, op(O_PRE, 0, 10'h0), 1, 2, 0, 1, C_PRE, 5'd6, 17'h0, 10'h0, 0, 0, 32'h0, 1, 1, 0);
        vecs[3]  = v(15, 1, R0, 0, 17'h0055, 1, 2, 0, 1, C_ACT, 5'd6, 17'h55, 10'h0, 0, 0, 32'h40, 2, 1, 0);
        vecs[4]  = v(14, 1, R0, 1, op(O_RD, 0, 10'h3), 1, 2, 0, 1, C_RD, 5'd6, 17'h55, 10'h3, 1, E_TRCD, 32'h40, 2, 2, 0);
        vecs[5]  = v(0,  1, R0, 1, op(O_RD, 1, 10'h7), 1, 2, 0, 1, C_RDA, 5'd6, 17'h55, 10'h7, 0, 0, 32'h0, 2, 3, 0);
        vecs[6]  = v(15, 1, R0, 0, 17'h0100, 1, 2, 0, 1, C_ACT, 5'd6, 17'h100, 10'h0, 0, 0, 32'h40, 3, 3, 0);
        vecs[7]  = v(0,  1, R0, 1, op(O_RD, 0, 10'h1), 0, 0, 0, 1, C_RD, 5'd0, 17'h0, 10'h1, 1, E_RWC, 32'h40, 3, 4, 0);
        vecs[8]  = v(0,  1, R0, 0, 17'h0200, 1, 2, 0, 1, C_ACT, 5'd6, 17'h200, 10'h0, 1, E_ACTO, 32'h40, 4, 4, 0);
        vecs[9]  = v(0,  1, R0, 1, op(O_REF, 0, 10'h0), 0, 0, 0, 1, C_REF, 5'd0, 17'h0, 10'h0, 1, E_REFO, 32'h40, 4, 4, 0);
        vecs[10] = v(0,  1, R0, 1, op(O_WR, 0, 10'h3FF), 1, 2, 0, 1, C_WR, 5'd6, 17'h200, 10'h3FF, 1, E_TRCD, 32'h40, 4, 4, 1);
        vecs[11] = v(0,  1, R0, 1, op(O_MRS, 0, 10'h0), 0, 0, 0, 1, C_MRS, 5'd0, 17'h0, 10'h0, 0, 0, 32'h40, 4, 4, 1);
        vecs[12] = v(0,  1, R0, 1, op(O_ZQC, 0, 10'h0), 0, 0, 0, 1, C_ZQC, 5'd0, 17'h0, 10'h0, 0, 0, 32'h40, 4, 4, 1);
        vecs[13] = v(0,  1, R0, 1, op(O_RFU, 0, 10'h0), 0, 0, 0, 1, C_RFU, 5'd0, 17'h0, 10'h0, 1, E_RFU, 32'h40, 4, 4, 1);
        vecs[14] = v(0,  1, 2'b00, 0, 17'h0001, 0, 0, 0, 0, C_NOP, 5'd0, 17'h0, 10'h0, 1, E_MCS, 32'h40, 4, 4, 1);
        vecs[15] = v(0,  1, R1, 0, 17'h0777, 1, 2, 0, 1, C_ACT, 5'd22, 17'h777, 10'h0, 0, 0, 32'h0040_0040, 5, 4, 1);
        vecs[16] = v(0,  1, R1, 0, 17'h0001, 3, 3, 0, 1, C_ACT, 5'd31, 17'h1, 10'h0, 0, 0, 32'h8040_0040, 6, 4, 1);
        vecs[17] = v(0,  1, R1, 1, op(O_PRE, 1, 10'h0), 0, 0, 0, 1, C_PREA, 5'd16, 17'h0, 10'h0, 0, 0, 32'h40, 6, 4, 1);
        vecs[18] = v(0,  1, R0, 1, op(O_NOP, 0, 10'h0), 1, 2, 0, 0, C_NOP, 5'd0, 17'h0, 10'h0, 0, 0, 32'h40, 6, 4, 1);
        vecs[19] = v(0,  0, R0, 0, 17'h0005, 0, 0, 0, 0, C_NOP, 5'd0, 17'h0, 10'h0, 0, 0, 32'h40, 6, 4, 1);
        vecs[20] = v(0,  1, DS, 1, op(O_NOP, 0, 10'h0), 0, 0, 1, 0, C_NOP, 5'd0, 17'h0, 10'h0, 0, 0, 32'h40, 0, 0, 0);

        rst_n = 1'b0;
        idle();
        #12;
        chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
        chk("reset err_valid", 32'(err_valid), 32'd0);
        chk("reset cmd_code", 32'(cmd_code), 32'd0);
        chk("reset cmd_row", 32'(cmd_row), 32'd0);
        chk("reset open_banks", open_banks, 32'd0);
        chk("reset act_cnt", 32'(act_cnt), 32'd0);
        chk("reset rd_cnt", 32'(rd_cnt), 32'd0);
        chk("reset wr_cnt", 32'(wr_cnt), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) apply(i, vecs[i]);

        // 17 ACT/PRE pairs on bank 5 (rank0 bg1 ba1): act_cnt sticks at 15.
        for (int p = 0; p < 17; p++) begin
            cyc(R0, 1'b0, 17'(p), 2'd1, 2'd1, 1'b0);
            cyc(R0, 1'b1, op(O_PRE, 1'b0, 10'd0), 2'd1, 2'd1, 1'b0);
        end
        chk("sat act_cnt", 32'(act_cnt), 32'd15);
        chk("sat rd_cnt", 32'(rd_cnt), 32'd0);

        // ACT one edge after PRE, with a coincident counter clear.
        cyc(R0, 1'b0, 17'h0009, 2'd1, 2'd1, 1'b1);
        chk("clr+act act_cnt", 32'(act_cnt), 32'd0);
        chk("clr+act cmd_valid", 32'(cmd_valid), 32'd1);
        chk("clr+act err_code", 32'(err_code), 32'(E_TRP));
        chk("clr+act open_banks", open_banks, 32'h60);

        // Asynchronous reset between edges, right after an ACT.
        cyc(R0, 1'b0, 17'h0003, 2'd0, 2'd0, 1'b0);
        chk("pre-rst cmd_valid", 32'(cmd_valid), 32'd1);
        chk("pre-rst act_cnt", 32'(act_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("mid-rst open_banks", open_banks, 32'd0);
        chk("mid-rst act_cnt", 32'(act_cnt), 32'd0);
        chk("mid-rst cmd_row", 32'(cmd_row), 32'd0);
        #3 rst_n = 1'b1;
        cyc(R0, 1'b0, 17'h0042, 2'd1, 2'd1, 1'b0);
        chk("post-rst cmd_valid", 32'(cmd_valid), 32'd1);
        chk("post-rst err_valid", 32'(err_valid), 32'd0);
        chk("post-rst open_banks", open_banks, 32'h20);
        chk("post-rst act_cnt", 32'(act_cnt), 32'd1);
        chk("post-rst cmd_row", 32'(cmd_row), 32'h42);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
